// File: rtl/matrix_operand_loader_pkg.sv
// Shared constants, size encodings and FSM state type for the matrix operand loader.
// Also provides the size-code to element-count decode used by the loader.
package matrix_operand_loader_pkg;

    localparam int ELEM_W    = 8;
    localparam int MAX_ELEMS = 25;
    localparam int MATRIX_W  = ELEM_W * MAX_ELEMS;

    localparam logic [1:0] SIZE_2X2 = 2'b00;
    localparam logic [1:0] SIZE_3X3 = 2'b01;
    localparam logic [1:0] SIZE_4X4 = 2'b10;
    localparam logic [1:0] SIZE_5X5 = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    function automatic logic [4:0] size_to_elems(input logic [1:0] size);
        logic [4:0] n;
        n = 5'd4;
        case (size)
            SIZE_2X2: n = 5'd4;
            SIZE_3X3: n = 5'd9;
            SIZE_4X4: n = 5'd16;
            SIZE_5X5: n = 5'd25;
            default:  n = 5'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/matrix_pack_reg.sv
// Packed-matrix register: MAX_ELEMS slots of ELEM_W bits with synchronous clear
// and a single-slot write port addressed by a 5-bit index.
module matrix_pack_reg #(
    parameter int ELEM_W    = 8,
    parameter int MAX_ELEMS = 25
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          wr_en,
    input  logic [4:0]                    wr_idx,
    input  logic [ELEM_W-1:0]             wr_data,
    output logic [ELEM_W*MAX_ELEMS-1:0]   matrix
);

    // Out-of-range indices match no slot, so the unused tail can never be written.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            matrix <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < MAX_ELEMS; k++) begin
                if (wr_idx == 5'(k)) begin
                    matrix[k*ELEM_W +: ELEM_W] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/matrix_operand_loader.sv
// Streams row-major signed elements into packed operand matrices A then B and
// presents them, with the latched size, to a downstream unit via valid/ready.
module matrix_operand_loader #(
    parameter int ELEM_W    = 8,
    parameter int MAX_ELEMS = 25
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    matrix_size,
    input  logic                          abort,
    input  logic [ELEM_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [ELEM_W*MAX_ELEMS-1:0]   matrix_A,
    output logic [ELEM_W*MAX_ELEMS-1:0]   matrix_B,
    output logic [1:0]                    size_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    import matrix_operand_loader_pkg::*;

    state_t     state;
    state_t     state_next;
    logic [4:0] count;
    logic [1:0] size_reg;
    logic       accept_start;
    logic       beat;
    logic       last_beat;
    logic       clear_bufs;
    logic       wr_a;
    logic       wr_b;

    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign size_out  = size_reg;

    assign accept_start = start && ((state == IDLE) || ((state == HOLD) && out_ready));
    assign beat         = in_valid && in_ready;
    assign last_beat    = (count == size_to_elems(size_reg) - 5'd1);
    assign clear_bufs   = abort || accept_start;
    assign wr_a         = beat && (state == LOAD_A) && !abort;
    assign wr_b         = beat && (state == LOAD_B) && !abort;

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept_start) state_next = LOAD_A;
                LOAD_A:  if (beat && last_beat) state_next = LOAD_B;
                LOAD_B:  if (beat && last_beat) state_next = HOLD;
                HOLD: begin
                    if (accept_start)   state_next = LOAD_A;
                    else if (out_ready) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Size survives abort so the consumer-facing size_out only changes on a new start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 5'd0;
            size_reg <= SIZE_2X2;
        end else begin
            state <= state_next;
            if (abort || accept_start) begin
                count <= 5'd0;
            end else if (beat) begin
                count <= last_beat ? 5'd0 : count + 5'd1;
            end
            if (accept_start && !abort) begin
                size_reg <= matrix_size;
            end
        end
    end

    matrix_pack_reg #(.ELEM_W(ELEM_W), .MAX_ELEMS(MAX_ELEMS)) u_pack_a (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_bufs),
        .wr_en   (wr_a),
        .wr_idx  (count),
        .wr_data (in_data),
        .matrix  (matrix_A)
    );

    matrix_pack_reg #(.ELEM_W(ELEM_W), .MAX_ELEMS(MAX_ELEMS)) u_pack_b (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_bufs),
        .wr_en   (wr_b),
        .wr_idx  (count),
        .wr_data (in_data),
        .matrix  (matrix_B)
    );

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed testbench for matrix_operand_loader; inputs change and outputs are
// sampled on the falling clock edge.
module tb_matrix_operand_loader;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   matrix_size;
    logic         abort;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [199:0] matrix_A;
    logic [199:0] matrix_B;
    logic [1:0]   size_out;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int checks;
    int errors;

    matrix_operand_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .matrix_size (matrix_size),
        .abort       (abort),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .matrix_A    (matrix_A),
        .matrix_B    (matrix_B),
        .size_out    (size_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [199:0] build(input int n, input logic [7:0] base, input logic [7:0] step);
        logic [199:0] r;
        r = '0;
        for (int k = 0; k < n; k++) begin
            r[k*8 +: 8] = base + 8'(k) * step;
        end
        return r;
    endfunction

    task automatic do_start(input logic [1:0] s);
        start = 1'b1;
        matrix_size = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data = d;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            checks++; errors++;
            $display("[TB] FAIL beat_timeout in_ready=%b required=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_pattern(input logic [1:0] s, input logic [7:0] ba, input logic [7:0] sa,
                                input logic [7:0] bb, input logic [7:0] sb);
        int n;
        n = (int'(s) + 2) * (int'(s) + 2);
        do_start(s);
        for (int k = 0; k < n; k++) send_beat(ba + 8'(k) * sa);
        for (int k = 0; k < n; k++) send_beat(bb + 8'(k) * sb);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_done_valid out_valid=%b required=1", out_valid);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL consume out_valid=%b busy=%b required=0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || size_out !== 2'b00 ||
            matrix_A !== '0 || matrix_B !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state in_ready=%b out_valid=%b busy=%b size=%b A=%h B=%h required all zero",
                     in_ready, out_valid, busy, size_out, matrix_A, matrix_B);
        end
    endtask

    task automatic test_basic_2x2();
        logic [7:0] vals [8];
        vals = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFE, 8'hFD, 8'hFC};
        do_start(2'b00);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL in_ready_rise in_ready=%b required=1", in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = vals[i];
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL beat_%0d_flags in_ready=%b out_valid=%b required=1 0", i, in_ready, out_valid);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cycle9_valid out_valid=%b required=1", out_valid);
        end
        checks++;
        if (matrix_A[31:0] !== 32'h04030201) begin
            errors++;
            $display("[TB] FAIL a_2x2 got=%h required=04030201", matrix_A[31:0]);
        end
        checks++;
        if (matrix_B[31:0] !== 32'hFCFDFEFF) begin
            errors++;
            $display("[TB] FAIL b_2x2 got=%h required=fcfdfeff", matrix_B[31:0]);
        end
        checks++;
        if (matrix_A[199:32] !== '0 || matrix_B[199:32] !== '0 || size_out !== 2'b00) begin
            errors++;
            $display("[TB] FAIL upper_2x2 A_hi=%h B_hi=%h size=%b required zeros", matrix_A[199:32], matrix_B[199:32], size_out);
        end
        consume();
    endtask

    task automatic test_5x5_gaps();
        int accepted;
        int gap;
        logic [7:0] ea;
        logic [7:0] eb;
        accepted = 0;
        do_start(2'b11);
        for (int k = 0; k < 50; k++) begin
            gap = int'($urandom_range(0, 2));
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL gap_early_valid beats=%0d out_valid=%b required=0", accepted, out_valid);
                end
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data = (k < 25) ? 8'(k) : 8'(0 - (k - 25));
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL gap_in_ready beat=%0d in_ready=%b required=1", k, in_ready);
            end
            @(negedge clk);
            accepted++;
            if (accepted < 50) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL gap_early_valid beats=%0d out_valid=%b required=0", accepted, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        for (int h = 0; h < 3; h++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_flags out_valid=%b in_ready=%b required=1 0", out_valid, in_ready);
            end
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 25; k++) begin
            ea = 8'(k);
            eb = 8'(0 - k);
            checks++;
            if (matrix_A[k*8 +: 8] !== ea || matrix_B[k*8 +: 8] !== eb) begin
                errors++;
                $display("[TB] FAIL slot_5x5_%0d A=%h B=%h required=%h %h", k, matrix_A[k*8 +: 8], matrix_B[k*8 +: 8], ea, eb);
            end
        end
        consume();
    endtask

    task automatic test_backpressure_abort();
        logic [199:0] ea;
        logic [199:0] eb;
        int i2;
        ea = build(9, 8'h01, 8'h01);
        eb = build(9, 8'h10, 8'h01);
        load_pattern(2'b01, 8'h01, 8'h01, 8'h10, 8'h01);
        for (int i = 0; i < 10; i++) begin
            i2 = i;
            out_ready = 1'b0;
            start = i2[0];
            matrix_size = i2[1:0];
            @(negedge clk);
            checks++;
            if (matrix_A !== ea || matrix_B !== eb || size_out !== 2'b01 || out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL frozen_%0d size=%b valid=%b A=%h B=%h required size=01 valid=1 A=%h B=%h",
                         i, size_out, out_valid, matrix_A, matrix_B, ea, eb);
            end
        end
        out_ready = 1'b1;
        start = 1'b1;
        matrix_size = 2'b10;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1 || size_out !== 2'b10 ||
            matrix_A !== '0 || matrix_B !== '0) begin
            errors++;
            $display("[TB] FAIL restart in_ready=%b valid=%b busy=%b size=%b A=%h B=%h required 1 0 1 10 zero zero",
                     in_ready, out_valid, busy, size_out, matrix_A, matrix_B);
        end
        for (int k = 0; k < 20; k++) send_beat(8'(k + 1));
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_abort in_ready=%b valid=%b required=1 0", in_ready, out_valid);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || size_out !== 2'b10 ||
            matrix_A !== '0 || matrix_B !== '0) begin
            errors++;
            $display("[TB] FAIL post_abort in_ready=%b busy=%b valid=%b size=%b A=%h B=%h required 0 0 0 10 zero zero",
                     in_ready, busy, out_valid, size_out, matrix_A, matrix_B);
        end
        in_valid = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_idle valid=%b in_ready=%b required=0 0", out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_hold();
        load_pattern(2'b10, 8'h05, 8'h01, 8'h09, 8'h01);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || size_out !== 2'b00 ||
            matrix_A !== '0 || matrix_B !== '0) begin
            errors++;
            $display("[TB] FAIL reset_hold in_ready=%b valid=%b busy=%b size=%b A=%h B=%h required all zero",
                     in_ready, out_valid, busy, size_out, matrix_A, matrix_B);
        end
        load_pattern(2'b00, 8'h21, 8'h01, 8'h31, 8'h01);
        checks++;
        if (matrix_A !== 200'h24232221 || matrix_B !== 200'h34333231 || size_out !== 2'b00) begin
            errors++;
            $display("[TB] FAIL after_reset_load A=%h B=%h size=%b required A=24232221 B=34333231 size=00",
                     matrix_A, matrix_B, size_out);
        end
        consume();
    endtask

    task automatic test_stale_slots();
        load_pattern(2'b11, 8'h7F, 8'h00, 8'h7F, 8'h00);
        checks++;
        if (matrix_A !== build(25, 8'h7F, 8'h00) || matrix_B !== build(25, 8'h7F, 8'h00)) begin
            errors++;
            $display("[TB] FAIL full_7f A=%h B=%h", matrix_A, matrix_B);
        end
        consume();
        load_pattern(2'b00, 8'h01, 8'h00, 8'h01, 8'h00);
        checks++;
        if (matrix_A !== 200'h01010101 || matrix_B !== 200'h01010101) begin
            errors++;
            $display("[TB] FAIL stale_slots A=%h B=%h required=01010101 in both", matrix_A, matrix_B);
        end
        consume();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        start = 1'b0;
        matrix_size = 2'b00;
        abort = 1'b0;
        in_data = 8'h00;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_2x2();
        test_5x5_gaps();
        test_backpressure_abort();
        test_reset_hold();
        test_stale_slots();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
